// File: rtl/mant_mul_seq_pkg.sv
// Shared FP16 constants and the mant_mul_seq FSM state type.
package mant_mul_seq_pkg;

    localparam int FP16_FRAC_W = 10;
    localparam int FP16_EXP_W  = 5;
    localparam int FP16_BIAS   = 15;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MUL,
        ST_NORM,
        ST_DONE
    } state_t;

endpackage

// File: rtl/mant_round.sv
// Normalises a [1,4) significand product into an FW-bit fraction plus exponent-increment flag.
// Define ROUND_NEAREST_EN for round-to-nearest-even; otherwise the fraction is truncated.
module mant_round #(
    parameter int FW = 10
) (
    input  logic [2*FW+1:0] prod,
    output logic [FW-1:0]   frac,
    output logic            inc
);

    logic          hi;
    logic [FW-1:0] frac_t;

    assign hi     = prod[2*FW+1];
    assign frac_t = hi ? prod[2*FW:FW+1] : prod[2*FW-1:FW];

`ifdef ROUND_NEAREST_EN
    logic        guard;
    logic        sticky;
    logic        up;
    logic [FW:0] sum;

    always_comb begin
        guard  = hi ? prod[FW] : prod[FW-1];
        sticky = hi ? |prod[FW-1:0] : |prod[FW-2:0];
        up     = guard & (sticky | frac_t[0]);
        sum    = {1'b0, frac_t} + {{FW{1'b0}}, up};
        // A carry out of an all-ones fraction wraps it to zero and bumps the exponent
        frac   = sum[FW-1:0];
        inc    = hi | sum[FW];
    end
`else
    logic unused_low;
    assign unused_low = ^prod[FW:0];

    always_comb begin
        frac = frac_t;
        inc  = hi;
    end
`endif

endmodule

// File: rtl/mant_mul_seq.sv
// Iterative radix-2 shift-and-add FP16 significand multiplier with valid/ready handshakes.
// Rounding mode selected by ROUND_NEAREST_EN (see mant_round).
module mant_mul_seq
    import mant_mul_seq_pkg::*;
#(
    parameter int FW = FP16_FRAC_W,
    parameter int CW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [FW-1:0] frac_a,
    input  logic [FW-1:0] frac_b,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [FW-1:0] frac_p,
    output logic          inc
);

    localparam int SW = FW + 1;
    localparam int PW = 2 * SW;

    state_t        state;
    logic [SW-1:0] mcand;
    logic [SW-1:0] mplier;
    logic [PW-1:0] acc;
    logic [CW-1:0] cnt;
    logic [FW-1:0] rnd_frac;
    logic          rnd_inc;

    mant_round #(.FW(FW)) u_round (
        .prod (acc),
        .frac (rnd_frac),
        .inc  (rnd_inc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            frac_p    <= '0;
            inc       <= 1'b0;
            acc       <= '0;
            cnt       <= '0;
            mcand     <= '0;
            mplier    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        mcand    <= {1'b1, frac_a};
                        mplier   <= {1'b1, frac_b};
                        acc      <= '0;
                        cnt      <= '0;
                        in_ready <= 1'b0;
                        state    <= ST_MUL;
                    end
                end
                ST_MUL: begin
                    if (mplier[cnt])
                        acc <= acc + (PW'(mcand) << cnt);
                    if (cnt == CW'(FW))
                        state <= ST_NORM;
                    else
                        cnt <= cnt + 1'b1;
                end
                ST_NORM: begin
                    frac_p    <= rnd_frac;
                    inc       <= rnd_inc;
                    out_valid <= 1'b1;
                    state     <= ST_DONE;
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
